// File: rtl/spike_pkg.sv
// -----------------------------------------------------------------------------
// spike_pkg
// Shared constants for the spike packet receive path: address/weight widths,
// packet field slices, FSM state encoding and small packet field helpers.
// No ports (package).
// -----------------------------------------------------------------------------
package spike_pkg;

    localparam int ADDR_W   = 12;
    localparam int WEIGHT_W = 32;
    localparam int PACKET_W = 24;

    localparam int SRC_MSB = 23;
    localparam int SRC_LSB = 12;
    localparam int DST_MSB = 11;
    localparam int DST_LSB = 0;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MATCH = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;

    typedef logic [PACKET_W-1:0] packet_t;

    function automatic logic [ADDR_W-1:0] pkt_src(input packet_t p);
        return p[SRC_MSB:SRC_LSB];
    endfunction

    function automatic logic [ADDR_W-1:0] pkt_dst(input packet_t p);
        return p[DST_MSB:DST_LSB];
    endfunction

endpackage

// File: rtl/spike_packet_fifo.sv
// -----------------------------------------------------------------------------
// spike_packet_fifo
// Synchronous FIFO with a synchronous flush, used to buffer incoming spike
// packets. DEPTH must be a power of 2 (>= 2) so pointers wrap naturally.
// Ports:
//   clk_i    in   clock, rising edge
//   rst_ni   in   asynchronous active-low reset
//   flush_i  in   synchronous flush; wins over push and pop
//   push_i   in   write request (ignored when full)
//   pop_i    in   read request (ignored when empty)
//   wdata_i  in   write data
//   rdata_o  out  head-of-queue data
//   empty_o  out  FIFO holds no entries
//   full_o   out  FIFO holds DEPTH entries
// -----------------------------------------------------------------------------
module spike_packet_fifo
    import spike_pkg::*;
#(
    parameter int WIDTH = PACKET_W,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible once counted.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/spike_packet_receiver.sv
// -----------------------------------------------------------------------------
// spike_packet_receiver
// Receive end of the spike packet link. Buffers {src, dst} packets in a FIFO,
// matches each against a programmable synapse table and hands the matched
// weight plus destination address to the accumulator array.
// Optional build macro RX_DROP_COUNT_EN adds a saturating count of packets
// that matched no table entry (output drop_count).
// Ports:
//   CLK, RESET        clock (rising) / asynchronous active-low reset
//   clear             synchronous timestep clear (FIFO + FSM, table kept)
//   packet_in/_valid  incoming packet, packet_ready = FIFO not full
//   cfg_*             synapse table write port
//   weight_out, dst_addr_out, weight_valid / weight_ready  output handshake
//   drop_count        unmatched packet count (RX_DROP_COUNT_EN only)
//
// state | meaning
// IDLE  | wait for a packet; pop FIFO head into pkt_q
// MATCH | compare pkt_q against valid table entries, lowest index wins
// EMIT  | present weight/dst until weight_ready
// -----------------------------------------------------------------------------
module spike_packet_receiver
    import spike_pkg::*;
#(
    parameter int NUM_SYNAPSES = 32,
    parameter int FIFO_DEPTH   = 4,
    localparam int IDX_W       = $clog2(NUM_SYNAPSES)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                clear,
    input  logic [PACKET_W-1:0] packet_in,
    input  logic                packet_valid,
    output logic                packet_ready,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_index,
    input  logic [ADDR_W-1:0]   cfg_src,
    input  logic [ADDR_W-1:0]   cfg_dst,
    input  logic [WEIGHT_W-1:0] cfg_weight,
    input  logic                cfg_entry_valid,
    output logic [WEIGHT_W-1:0] weight_out,
    output logic [ADDR_W-1:0]   dst_addr_out,
    output logic                weight_valid,
`ifdef RX_DROP_COUNT_EN
    output logic [15:0]         drop_count,
`endif
    input  logic                weight_ready
);

    logic [1:0]              state_q,  state_d;
    packet_t                 pkt_q,    pkt_d;
    logic [WEIGHT_W-1:0]     weight_q, weight_d;
    logic [ADDR_W-1:0]       dst_q,    dst_d;

    logic [NUM_SYNAPSES-1:0] tbl_valid_q;
    logic [ADDR_W-1:0]       tbl_src_q    [NUM_SYNAPSES];
    logic [ADDR_W-1:0]       tbl_dst_q    [NUM_SYNAPSES];
    logic [WEIGHT_W-1:0]     tbl_weight_q [NUM_SYNAPSES];

    logic                    fifo_empty;
    logic                    fifo_full;
    logic                    fifo_pop;
    packet_t                 fifo_head;

    logic                    hit;
    logic [WEIGHT_W-1:0]     hit_weight;
    logic [ADDR_W-1:0]       hit_dst;

    // A packet offered during clear is refused even if packet_ready reads 1.
    spike_packet_fifo #(
        .WIDTH (PACKET_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (CLK),
        .rst_ni  (RESET),
        .flush_i (clear),
        .push_i  (packet_valid),
        .pop_i   (fifo_pop),
        .wdata_i (packet_in),
        .rdata_o (fifo_head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign packet_ready = !fifo_full;
    assign weight_valid = (state_q == EMIT);
    assign weight_out   = weight_q;
    assign dst_addr_out = dst_q;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            tbl_valid_q <= '0;
        end else if (cfg_we) begin
            tbl_valid_q[cfg_index] <= cfg_entry_valid;
        end
    end

    always_ff @(posedge CLK) begin
        if (cfg_we) begin
            tbl_src_q[cfg_index]    <= cfg_src;
            tbl_dst_q[cfg_index]    <= cfg_dst;
            tbl_weight_q[cfg_index] <= cfg_weight;
        end
    end

    // Scan from the top down so the lowest matching index is assigned last.
    always_comb begin
        hit        = 1'b0;
        hit_weight = '0;
        hit_dst    = '0;
        for (int i = NUM_SYNAPSES - 1; i >= 0; i--) begin
            if (tbl_valid_q[i] &&
                (tbl_src_q[i] == pkt_src(pkt_q)) &&
                (tbl_dst_q[i] == pkt_dst(pkt_q))) begin
                hit        = 1'b1;
                hit_weight = tbl_weight_q[i];
                hit_dst    = tbl_dst_q[i];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pkt_d    = pkt_q;
        weight_d = weight_q;
        dst_d    = dst_q;
        fifo_pop = 1'b0;
        if (clear) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        pkt_d    = fifo_head;
                        state_d  = MATCH;
                    end
                end
                MATCH: begin
                    if (hit) begin
                        weight_d = hit_weight;
                        dst_d    = hit_dst;
                        state_d  = EMIT;
                    end else begin
                        state_d  = IDLE;
                    end
                end
                EMIT: begin
                    if (weight_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            pkt_q    <= '0;
            weight_q <= '0;
            dst_q    <= '0;
        end else begin
            state_q  <= state_d;
            pkt_q    <= pkt_d;
            weight_q <= weight_d;
            dst_q    <= dst_d;
        end
    end

`ifdef RX_DROP_COUNT_EN
    logic [15:0] drop_cnt_q;

    // A packet flushed by clear while in MATCH is discarded, not dropped.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            drop_cnt_q <= '0;
        end else if ((state_q == MATCH) && !hit && !clear &&
                     (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end

    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_spike_packet_receiver.sv
module tb_spike_packet_receiver;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic        clear = 1'b0;
    logic [23:0] packet_in = '0;
    logic        packet_valid = 1'b0;
    logic        packet_ready;
    logic        cfg_we = 1'b0;
    logic [4:0]  cfg_index = '0;
    logic [11:0] cfg_src = '0;
    logic [11:0] cfg_dst = '0;
    logic [31:0] cfg_weight = '0;
    logic        cfg_entry_valid = 1'b0;
    logic [31:0] weight_out;
    logic [11:0] dst_addr_out;
    logic        weight_valid;
    logic        weight_ready = 1'b0;
`ifdef RX_DROP_COUNT_EN
    logic [15:0] drop_count;
`endif

    spike_packet_receiver dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .clear           (clear),
        .packet_in       (packet_in),
        .packet_valid    (packet_valid),
        .packet_ready    (packet_ready),
        .cfg_we          (cfg_we),
        .cfg_index       (cfg_index),
        .cfg_src         (cfg_src),
        .cfg_dst         (cfg_dst),
        .cfg_weight      (cfg_weight),
        .cfg_entry_valid (cfg_entry_valid),
        .weight_out      (weight_out),
        .dst_addr_out    (dst_addr_out),
        .weight_valid    (weight_valid),
`ifdef RX_DROP_COUNT_EN
        .drop_count      (drop_count),
`endif
        .weight_ready    (weight_ready)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] w;
        logic [11:0] d;
    } exp_t;
    exp_t sb[$];

    bit          m_valid [32];
    logic [11:0] m_src   [32];
    logic [11:0] m_dst   [32];
    logic [31:0] m_wt    [32];
    int          exp_drops = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input int idx, input logic [11:0] s, input logic [11:0] d,
                             input logic [31:0] w, input bit v);
        @(posedge CLK); #1;
        cfg_we = 1'b1; cfg_index = 5'(idx); cfg_src = s; cfg_dst = d;
        cfg_weight = w; cfg_entry_valid = v;
        @(posedge CLK); #1;
        cfg_we = 1'b0;
        m_valid[idx] = v; m_src[idx] = s; m_dst[idx] = d; m_wt[idx] = w;
    endtask

    task automatic lookup(input logic [23:0] p, output bit h, output exp_t e);
        h = 0; e.w = '0; e.d = '0;
        for (int i = 0; i < 32; i++) begin
            if (!h && m_valid[i] && m_src[i] == p[23:12] && m_dst[i] == p[11:0]) begin
                h = 1; e.w = m_wt[i]; e.d = m_dst[i];
            end
        end
    endtask

    // Offers a packet and returns one step after the edge that accepted it.
    task automatic send(input logic [23:0] p);
        bit   ok = 0;
        bit   h;
        exp_t e;
        packet_in = p;
        packet_valid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge CLK);
            if (packet_ready) begin
                @(posedge CLK);
                ok = 1;
            end
        end
        #1 packet_valid = 1'b0;
        if (!ok) check_val("accept_timeout", packet_ready, 1'b1);
        else begin
            lookup(p, h, e);
            if (h) sb.push_back(e);
            else   exp_drops++;
        end
    endtask

    task automatic wait_wv();
        bit seen = 0;
        for (int n = 0; n < 30 && !seen; n++) begin
            @(negedge CLK);
            if (weight_valid) seen = 1;
        end
        if (!seen) check_val("wv_timeout", weight_valid, 1'b1);
    endtask

    always @(negedge CLK) begin : mon
        exp_t e;
        if (RESET && !clear && weight_valid && weight_ready) begin
            if (sb.size() == 0) check_val("spurious_weight", weight_valid, 1'b0);
            else begin
                e = sb.pop_front();
                check_val("weight_out", weight_out, e.w);
                check_val("dst_addr_out", dst_addr_out, e.d);
            end
        end
    end

    initial begin : main
        bit seen;
        for (int i = 0; i < 32; i++) m_valid[i] = 0;

        // reset values
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_val("rst_ready", packet_ready, 1'b1);
        check_val("rst_wvalid", weight_valid, 1'b0);
        check_val("rst_wout", weight_out, 32'h0);
        check_val("rst_dst", dst_addr_out, 12'h0);
`ifdef RX_DROP_COUNT_EN
        check_val("rst_drops", drop_count, 16'h0);
`endif
        @(posedge CLK); #1 RESET = 1'b1;

        // basic match and latency
        cfg_write(3, 12'h00A, 12'h014, 32'h3F800000, 1);
        send(24'h00A014);
        @(negedge CLK); check_val("lat_e0", weight_valid, 1'b0);
        @(negedge CLK); check_val("lat_e1", weight_valid, 1'b0);
        @(negedge CLK); check_val("lat_e2", weight_valid, 1'b1);
        check_val("t1_weight", weight_out, 32'h3F800000);
        check_val("t1_dst", dst_addr_out, 12'h014);
        @(posedge CLK); #1 weight_ready = 1'b1;
        repeat (3) @(posedge CLK); #1;

        // unmatched packet dropped
        send(24'h00B014);
        seen = 0;
        repeat (4) begin @(negedge CLK); seen |= weight_valid; end
        check_val("nomatch_wv", seen, 1'b0);
        check_val("nomatch_ready", packet_ready, 1'b1);
`ifdef RX_DROP_COUNT_EN
        check_val("nomatch_drops", drop_count, 16'(exp_drops));
`endif

        // back-pressure: fill FIFO plus EMIT, then drain in order
        for (int k = 0; k < 6; k++)
            cfg_write(10 + k, 12'(12'h100 + k), 12'(12'h200 + k), 32'h41000000 + k, 1);
        @(posedge CLK); #1 weight_ready = 1'b0;
        for (int k = 0; k < 5; k++) send({12'(12'h100 + k), 12'(12'h200 + k)});
        @(negedge CLK); check_val("full_ready", packet_ready, 1'b0);
        @(posedge CLK); #1 weight_ready = 1'b1;
        send({12'h105, 12'h205});
        repeat (25) @(posedge CLK); #1;
        check_val("drain_sb", sb.size(), 0);

        // lowest index wins
        cfg_write(2, 12'h001, 12'h002, 32'h40000000, 1);
        cfg_write(7, 12'h001, 12'h002, 32'h40400000, 1);
        weight_ready = 1'b0;
        send(24'h001002);
        wait_wv();
        check_val("lowest_idx", weight_out, 32'h40000000);
        @(posedge CLK); #1 weight_ready = 1'b1;
        repeat (4) @(posedge CLK); #1;

        // clear during EMIT with packets queued
        weight_ready = 1'b0;
        for (int k = 0; k < 3; k++) send(24'h00A014);
        wait_wv();
        @(posedge CLK); #1;
        clear = 1'b1; packet_in = 24'h00A014; packet_valid = 1'b1;
        sb.delete();
        @(posedge CLK); #1;
        clear = 1'b0; packet_valid = 1'b0;
        @(negedge CLK);
        check_val("clear_wv", weight_valid, 1'b0);
        check_val("clear_ready", packet_ready, 1'b1);
        @(posedge CLK); #1 weight_ready = 1'b1;
        seen = 0;
        repeat (8) begin @(negedge CLK); seen |= weight_valid; end
        check_val("clear_no_weight", seen, 1'b0);
        @(posedge CLK); #1;
        send(24'h00A014);
        repeat (6) @(posedge CLK); #1;
        check_val("clear_rematch", sb.size(), 0);

        // asynchronous reset mid-EMIT
        weight_ready = 1'b0;
        send(24'h00A014);
        wait_wv();
        @(posedge CLK); #2 RESET = 1'b0;
        #1;
        check_val("arst_wv", weight_valid, 1'b0);
        check_val("arst_wout", weight_out, 32'h0);
        sb.delete();
        for (int i = 0; i < 32; i++) m_valid[i] = 0;
        exp_drops = 0;
        repeat (2) @(posedge CLK); #1 RESET = 1'b1;
        check_val("arst_ready", packet_ready, 1'b1);
        weight_ready = 1'b1;
        send(24'h00A014);
        seen = 0;
        repeat (6) begin @(negedge CLK); seen |= weight_valid; end
        check_val("arst_table_cleared", seen, 1'b0);
`ifdef RX_DROP_COUNT_EN
        check_val("arst_drops", drop_count, 16'(exp_drops));
`endif

        repeat (5) @(posedge CLK); #1;
        check_val("final_sb", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
